tmnt_layer_mixer: RTL and testbench

- Sits directly downstream of the plane data processor.
- Takes the per-pixel layer A/B/fix outputs and a sprite pixel, resolves priority, and looks up the colour in an internal palette RAM.
- Emits registered 5:5:5 RGB with delayed blanking/sync to the video output.
- Also hosts the CPU-side palette byte port.

---
 rtl/tmnt_video_pkg.sv | 17 +
 rtl/tmnt_palette_ram.sv | 35 +++
 rtl/tmnt_layer_mixer.sv | 141 ++++++++++++++
 tb/tb_tmnt_layer_mixer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmnt_video_pkg.sv
// Shared video constants for the layer mixer:
// palette banks, palette size and RGB555 fields.
package tmnt_video_pkg;

  localparam int PAL_AW = 10;

  localparam logic [1:0] BANK_FIX = 2'b00;
  localparam logic [1:0] BANK_A   = 2'b01;
  localparam logic [1:0] BANK_B   = 2'b10;
  localparam logic [1:0] BANK_OBJ = 2'b11;

  localparam int CH_W  = 5;
  localparam int R_LSB = 0;
  localparam int G_LSB = 5;
  localparam int B_LSB = 10;

endpackage

// File: rtl/tmnt_palette_ram.sv
// Palette RAM: byte-writable CPU port plus a
// read-only video port, both synchronous.
module tmnt_palette_ram
  import tmnt_video_pkg::*;
#(
  parameter int AW = PAL_AW
) (
  input  logic          clk,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_lane,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic [15:0]   cpu_q,
  input  logic          vid_en,
  input  logic [AW-1:0] vid_addr,
  output logic [15:0]   vid_q
);

  logic [15:0] mem [2**AW];

  // CPU side: byte-lane write and registered word read
  always_ff @(posedge clk) begin
    if (cpu_we) begin
      if (cpu_lane) mem[cpu_addr][15:8] <= cpu_din;
      else          mem[cpu_addr][7:0]  <= cpu_din;
    end
    cpu_q <= mem[cpu_addr];
  end

  // Video side: read-first, so a same-cycle write shows next read
  always_ff @(posedge clk) begin
    if (vid_en) vid_q <= mem[vid_addr];
  end

endmodule

// File: rtl/tmnt_layer_mixer.sv
// Layer/sprite priority mixer with palette lookup
// and aligned blank/sync, plus CPU palette port.
module tmnt_layer_mixer #(
  parameter int PAL_AW   = tmnt_video_pkg::PAL_AW,
  parameter int PIPE_LAT = 3
) (
  input  logic        clk_24M,
  input  logic        nRES,
  input  logic        ce_6M,
  input  logic [11:0] DSA,
  input  logic [11:0] DSB,
  input  logic [7:0]  DFI,
  input  logic        NSAC,
  input  logic        NSBC,
  input  logic        NFIC,
  input  logic [7:0]  OB,
  input  logic        OBOP,
  input  logic        OBPRI,
  input  logic        PRI,
  input  logic        NHBK,
  input  logic        NVBK,
  input  logic        NCSY,
  input  logic [10:0] CPU_A,
  input  logic [7:0]  CPU_DIN,
  input  logic        CPU_WE,
  output logic [7:0]  CPU_DOUT,
  output logic [4:0]  RGB_R,
  output logic [4:0]  RGB_G,
  output logic [4:0]  RGB_B,
  output logic        O_NBLK,
  output logic        O_NCSY
);

  import tmnt_video_pkg::BANK_FIX;
  import tmnt_video_pkg::BANK_A;
  import tmnt_video_pkg::BANK_B;
  import tmnt_video_pkg::BANK_OBJ;
  import tmnt_video_pkg::CH_W;
  import tmnt_video_pkg::R_LSB;
  import tmnt_video_pkg::G_LSB;
  import tmnt_video_pkg::B_LSB;

  logic [PAL_AW-1:0]   nxt_idx;
  logic [PAL_AW-1:0]   front_idx;
  logic [PAL_AW-1:0]   back_idx;
  logic                front_op;
  logic [PAL_AW-1:0]   idx;
  logic [PIPE_LAT-1:0] blk_sr;
  logic [PIPE_LAT-1:0] sync_sr;
  logic [15:0]         w;
  logic [15:0]         cpu_word;
  logic                cpu_lane;
  logic                cpu_vld;
  logic                unused_bits;

  assign unused_bits = ^{DSA[11:8], DSB[11:8], w[15]};

  // Priority resolve: fix, front sprite, front layer,
  // rear sprite, then back layer as the backdrop
  always_comb begin
    front_op  = PRI ? NSBC : NSAC;
    front_idx = PRI ? {BANK_B, DSB[7:0]}
                    : {BANK_A, DSA[7:0]};
    back_idx  = PRI ? {BANK_A, DSA[7:0]}
                    : {BANK_B, DSB[7:0]};
    nxt_idx   = back_idx;
    if (NFIC)
      nxt_idx = {BANK_FIX, DFI};
    else if (OBOP && !OBPRI)
      nxt_idx = {BANK_OBJ, OB};
    else if (front_op)
      nxt_idx = front_idx;
    else if (OBOP)
      nxt_idx = {BANK_OBJ, OB};
  end

  // Stage 1: sample index and enter blank/sync delay line
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      idx     <= '0;
      blk_sr  <= '0;
      sync_sr <= '0;
    end else if (ce_6M) begin
      idx     <= nxt_idx;
      blk_sr  <= {blk_sr[PIPE_LAT-2:0], NHBK & NVBK};
      sync_sr <= {sync_sr[PIPE_LAT-2:0], NCSY};
    end
  end

  tmnt_palette_ram #(
    .AW (PAL_AW)
  ) u_pal (
    .clk      (clk_24M),
    .cpu_addr (CPU_A[10:1]),
    .cpu_lane (CPU_A[0]),
    .cpu_din  (CPU_DIN),
    .cpu_we   (CPU_WE),
    .cpu_q    (cpu_word),
    .vid_en   (ce_6M),
    .vid_addr (idx),
    .vid_q    (w)
  );

  // Stage 3: split RGB555, black during blanking
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      RGB_R <= '0;
      RGB_G <= '0;
      RGB_B <= '0;
    end else if (ce_6M) begin
      if (blk_sr[PIPE_LAT-2]) begin
        RGB_R <= w[R_LSB +: CH_W];
        RGB_G <= w[G_LSB +: CH_W];
        RGB_B <= w[B_LSB +: CH_W];
      end else begin
        RGB_R <= '0;
        RGB_G <= '0;
        RGB_B <= '0;
      end
    end
  end

  assign O_NBLK = blk_sr[PIPE_LAT-1];
  assign O_NCSY = sync_sr[PIPE_LAT-1];

  // CPU read lane tracking; output held at 0 until first clock
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      cpu_vld  <= 1'b0;
      cpu_lane <= 1'b0;
    end else begin
      cpu_vld  <= 1'b1;
      cpu_lane <= CPU_A[0];
    end
  end

  assign CPU_DOUT = !cpu_vld ? 8'd0
                  : cpu_lane ? cpu_word[15:8]
                  : cpu_word[7:0];

endmodule

// File: tb/tb_tmnt_layer_mixer.sv
// Bench for tmnt_layer_mixer: directed priority,
// CPU port and reset cases plus random streaming.
module tb_tmnt_layer_mixer;

  logic        clk_24M = 1'b0;
  logic        nRES;
  logic        ce_6M;
  logic [11:0] DSA, DSB;
  logic [7:0]  DFI, OB;
  logic        NSAC, NSBC, NFIC;
  logic        OBOP, OBPRI, PRI;
  logic        NHBK, NVBK, NCSY;
  logic [10:0] CPU_A;
  logic [7:0]  CPU_DIN;
  logic        CPU_WE;
  logic [7:0]  CPU_DOUT;
  logic [4:0]  RGB_R, RGB_G, RGB_B;
  logic        O_NBLK, O_NCSY;

  int total = 0;
  int bad   = 0;

  logic [15:0] pal [1024];
  wire  [16:0] obs = {RGB_R, RGB_G, RGB_B, O_NBLK, O_NCSY};

  tmnt_layer_mixer dut (
    .clk_24M  (clk_24M),
    .nRES     (nRES),
    .ce_6M    (ce_6M),
    .DSA      (DSA),
    .DSB      (DSB),
    .DFI      (DFI),
    .NSAC     (NSAC),
    .NSBC     (NSBC),
    .NFIC     (NFIC),
    .OB       (OB),
    .OBOP     (OBOP),
    .OBPRI    (OBPRI),
    .PRI      (PRI),
    .NHBK     (NHBK),
    .NVBK     (NVBK),
    .NCSY     (NCSY),
    .CPU_A    (CPU_A),
    .CPU_DIN  (CPU_DIN),
    .CPU_WE   (CPU_WE),
    .CPU_DOUT (CPU_DOUT),
    .RGB_R    (RGB_R),
    .RGB_G    (RGB_G),
    .RGB_B    (RGB_B),
    .O_NBLK   (O_NBLK),
    .O_NCSY   (O_NCSY)
  );

  always #5 clk_24M = ~clk_24M;

  // Reference: priority rules and palette model
  function automatic logic [16:0] ref_out();
    logic [9:0]  i;
    logic [15:0] w;
    logic        bl;
    if (NFIC)
      i = {2'b00, DFI};
    else if (OBOP && !OBPRI)
      i = {2'b11, OB};
    else if (PRI ? NSBC : NSAC)
      i = PRI ? {2'b10, DSB[7:0]} : {2'b01, DSA[7:0]};
    else if (OBOP)
      i = {2'b11, OB};
    else
      i = PRI ? {2'b01, DSA[7:0]} : {2'b10, DSB[7:0]};
    w  = pal[i];
    bl = NHBK & NVBK;
    if (bl) return {w[4:0], w[9:5], w[14:10], 1'b1, NCSY};
    return {15'd0, 1'b0, NCSY};
  endfunction

  // One pixel tick: ce high for one clk in four
  task automatic tick();
    @(negedge clk_24M);
    ce_6M = 1'b1;
    @(negedge clk_24M);
    ce_6M = 1'b0;
    repeat (2) @(negedge clk_24M);
  endtask

  // Pixel tick with a CPU write on the ce cycle
  task automatic tick_wr(input logic [10:0] a,
                         input logic [7:0] d);
    @(negedge clk_24M);
    ce_6M   = 1'b1;
    CPU_A   = a;
    CPU_DIN = d;
    CPU_WE  = 1'b1;
    @(negedge clk_24M);
    ce_6M  = 1'b0;
    CPU_WE = 1'b0;
    repeat (2) @(negedge clk_24M);
  endtask

  task automatic cpu_wr(input logic [10:0] a,
                        input logic [7:0] d);
    CPU_A   = a;
    CPU_DIN = d;
    CPU_WE  = 1'b1;
    @(negedge clk_24M);
    CPU_WE  = 1'b0;
    if (a[0]) pal[a[10:1]][15:8] = d;
    else      pal[a[10:1]][7:0]  = d;
  endtask

  task automatic cpu_wr16(input logic [9:0] e,
                          input logic [15:0] v);
    cpu_wr({e, 1'b0}, v[7:0]);
    cpu_wr({e, 1'b1}, v[15:8]);
  endtask

  task automatic set_px(input logic fic, input logic sac,
                        input logic sbc, input logic op,
                        input logic opri, input logic pr);
    NFIC = fic; NSAC = sac; NSBC = sbc;
    OBOP = op; OBPRI = opri; PRI = pr;
    NHBK = 1'b1; NVBK = 1'b1; NCSY = 1'b1;
  endtask

  task automatic rand_px();
    NFIC  = ($urandom_range(0, 3) == 0);
    NSAC  = 1'($urandom_range(0, 1));
    NSBC  = 1'($urandom_range(0, 1));
    OBOP  = 1'($urandom_range(0, 1));
    OBPRI = 1'($urandom_range(0, 1));
    PRI   = 1'($urandom_range(0, 1));
    DSA   = 12'($urandom);
    DSB   = 12'($urandom);
    DFI   = 8'($urandom);
    OB    = 8'($urandom);
    NHBK  = ($urandom_range(0, 7) != 0);
    NVBK  = ($urandom_range(0, 7) != 0);
    NCSY  = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    nRES = 1'b0;
    repeat (3) @(negedge clk_24M);
    total++;
    if (obs !== 17'd0 || CPU_DOUT !== 8'd0) begin
      bad++;
      $display("FAIL reset got=%h/%h exp=0/0", obs, CPU_DOUT);
    end
    nRES = 1'b1;
  endtask

  task automatic test_priority();
    cpu_wr16(10'h000, 16'h001F);
    cpu_wr16(10'h100, 16'h03E0);
    cpu_wr16(10'h200, 16'h7C00);
    cpu_wr16(10'h300, 16'h7FFF);
    DSA = 12'hF00; DSB = 12'hE00; DFI = 8'h00; OB = 8'h00;
    set_px(1, 1, 1, 1, 0, 0);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {5'd31, 5'd0, 5'd0}) begin
      bad++;
      $display("FAIL prio_fix got=%h exp=%h",
               {RGB_R, RGB_G, RGB_B}, {5'd31, 5'd0, 5'd0});
    end
    set_px(1, 1, 1, 1, 1, 1);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {5'd31, 5'd0, 5'd0}) begin
      bad++;
      $display("FAIL prio_fix_opri got=%h", {RGB_R, RGB_G, RGB_B});
    end
    set_px(0, 1, 1, 1, 0, 0);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {5'd31, 5'd31, 5'd31}) begin
      bad++;
      $display("FAIL prio_obj got=%h exp=%h",
               {RGB_R, RGB_G, RGB_B}, {5'd31, 5'd31, 5'd31});
    end
  endtask

  task automatic test_layer_order();
    set_px(0, 1, 1, 1, 1, 0);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {5'd0, 5'd31, 5'd0}) begin
      bad++;
      $display("FAIL order_a got=%h", {RGB_R, RGB_G, RGB_B});
    end
    set_px(0, 1, 1, 1, 1, 1);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {5'd0, 5'd0, 5'd31}) begin
      bad++;
      $display("FAIL order_b got=%h", {RGB_R, RGB_G, RGB_B});
    end
    set_px(0, 0, 0, 1, 1, 0);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {5'd31, 5'd31, 5'd31}) begin
      bad++;
      $display("FAIL order_obj got=%h", {RGB_R, RGB_G, RGB_B});
    end
  endtask

  task automatic test_backdrop();
    logic [15:0] w;
    w = 16'h5A5A;
    cpu_wr16(10'h240, w);
    DSB = 12'h040;
    set_px(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {w[4:0], w[9:5], w[14:10]}) begin
      bad++;
      $display("FAIL backdrop got=%h exp=%h",
               {RGB_R, RGB_G, RGB_B}, {w[4:0], w[9:5], w[14:10]});
    end
  endtask

  task automatic test_cpu_port();
    logic [15:0] w;
    w = 16'h1234;
    cpu_wr(11'h003, 8'h12);
    cpu_wr(11'h002, 8'h34);
    CPU_A = 11'h003;
    @(negedge clk_24M);
    total++;
    if (CPU_DOUT !== 8'h12) begin
      bad++;
      $display("FAIL cpu_rd_hi got=%h exp=12", CPU_DOUT);
    end
    CPU_A = 11'h002;
    @(negedge clk_24M);
    total++;
    if (CPU_DOUT !== 8'h34) begin
      bad++;
      $display("FAIL cpu_rd_lo got=%h exp=34", CPU_DOUT);
    end
    DFI = 8'h01;
    set_px(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    total++;
    if ({RGB_R, RGB_G, RGB_B} !== {w[4:0], w[9:5], w[14:10]}) begin
      bad++;
      $display("FAIL cpu_video got=%h exp=%h",
               {RGB_R, RGB_G, RGB_B}, {w[4:0], w[9:5], w[14:10]});
    end
  endtask

  task automatic test_random();
    logic [16:0] q [$];
    for (int i = 0; i < 60; i++) begin
      rand_px();
      q.push_back(ref_out());
      tick();
      if (i >= 2) begin
        total++;
        if (obs !== q[i-2]) begin
          bad++;
          $display("FAIL random[%0d] got=%h exp=%h", i, obs, q[i-2]);
        end
      end
    end
  endtask

  task automatic test_blank_pulse();
    logic [16:0] q [$];
    for (int i = 0; i < 9; i++) begin
      rand_px();
      NVBK = 1'b1;
      NHBK = (i != 3);
      q.push_back(ref_out());
      tick();
      if (i >= 2) begin
        total++;
        if (obs !== q[i-2] || O_NBLK !== (i != 5)) begin
          bad++;
          $display("FAIL blank[%0d] got=%h exp=%h", i, obs, q[i-2]);
        end
      end
    end
  endtask

  task automatic test_rdw();
    logic [16:0] q [$];
    logic [7:0]  nb;
    DFI = 8'hAA;
    set_px(1, 0, 0, 0, 0, 0);
    nb = ~pal[10'h0AA][7:0];
    q.push_back(ref_out());
    tick();
    pal[10'h0AA][7:0] = nb;
    q.push_back(ref_out());
    tick_wr(11'h154, nb);
    for (int i = 2; i < 4; i++) begin
      q.push_back(ref_out());
      tick();
      total++;
      if (obs !== q[i-2]) begin
        bad++;
        $display("FAIL rdw[%0d] got=%h exp=%h", i, obs, q[i-2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] q [$];
    OB = 8'h00;
    set_px(0, 0, 0, 1, 0, 0);
    repeat (3) tick();
    total++;
    if (obs !== {15'h7FFF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset got=%h exp=%h", obs, {15'h7FFF, 2'b11});
    end
    @(negedge clk_24M);
    #2 nRES = 1'b0;
    #1;
    total++;
    if (obs !== 17'd0 || CPU_DOUT !== 8'd0) begin
      bad++;
      $display("FAIL async_reset got=%h/%h exp=0/0", obs, CPU_DOUT);
    end
    repeat (3) @(negedge clk_24M);
    nRES = 1'b1;
    q.push_back(17'd0);
    q.push_back(17'd0);
    for (int i = 0; i < 8; i++) begin
      rand_px();
      NHBK = 1'b1;
      NVBK = 1'b1;
      q.push_back(ref_out());
      tick();
      total++;
      if (obs !== q[i]) begin
        bad++;
        $display("FAIL post_reset[%0d] got=%h exp=%h", i, obs, q[i]);
      end
    end
  endtask

  initial begin
    ce_6M = 1'b0;
    CPU_WE = 1'b0; CPU_A = '0; CPU_DIN = '0;
    DSA = '0; DSB = '0; DFI = '0; OB = '0;
    set_px(0, 0, 0, 0, 0, 0);
    test_reset();
    for (int e = 0; e < 1024; e++)
      cpu_wr16(10'(e), 16'($urandom));
    test_priority();
    test_layer_order();
    test_backdrop();
    test_cpu_port();
    test_random();
    test_blank_pulse();
    test_rdw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
